// File: rtl/seg7_pkg.sv
// Shared constants, types and helpers for the 7-segment sequencer.
package seg7_pkg;

    localparam int unsigned NUM_ANIM = 12;
    localparam int unsigned ANIM_W   = 4;
    localparam int unsigned CNT_W    = 4;
    localparam int unsigned LOOP_W   = 4;
    localparam int unsigned SPEED_W  = 3;

    typedef logic [ANIM_W-1:0] anim_t;

    localparam anim_t ANIM_LAST = anim_t'(NUM_ANIM - 1);

    // Number of frames in each animation; ids beyond ANIM_LAST are unreachable.
    function automatic logic [CNT_W-1:0] frame_len(input anim_t a);
        logic [CNT_W-1:0] len;
        len = CNT_W'(2);
        case (a)
            4'd0:                     len = CNT_W'(10);
            4'd1:                     len = CNT_W'(12);
            4'd2, 4'd3, 4'd4,
            4'd5, 4'd6:               len = CNT_W'(6);
            4'd8, 4'd9:               len = CNT_W'(4);
            default:                  len = CNT_W'(2);
        endcase
        return len;
    endfunction

    // Next animation id, wrapping after the last one.
    function automatic anim_t anim_next(input anim_t a);
        return (a >= ANIM_LAST) ? anim_t'(0) : a + anim_t'(1);
    endfunction

endpackage

// File: rtl/seg7_prescaler.sv
// Frame-rate prescaler: period is PRESCALE_BASE << speed clock cycles.
module seg7_prescaler
    import seg7_pkg::*;
#(
    parameter int unsigned PRESCALE_BASE = 1000000,
    parameter int unsigned PRESCALE_W    = 27
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               ena_i,
    input  logic               clr_i,
    input  logic [SPEED_W-1:0] speed_i,
    output logic               tick_c_o
);

    logic [PRESCALE_W-1:0] cnt_q;
    logic [PRESCALE_W-1:0] cnt_d;
    logic [PRESCALE_W-1:0] limit_m1;

    // Terminal count for the current speed; >= also catches a speed drop mid-period.
    always_comb begin
        limit_m1 = (PRESCALE_W'(PRESCALE_BASE) << speed_i) - PRESCALE_W'(1);
        tick_c_o = (cnt_q >= limit_m1);
    end

    // Next count: hold when disabled, wrap on tick or clear request.
    always_comb begin
        cnt_d = cnt_q;
        if (ena_i) begin
            if (clr_i || tick_c_o) begin
                cnt_d = '0;
            end else begin
                cnt_d = cnt_q + PRESCALE_W'(1);
            end
        end
    end

    // Count register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

endmodule

// File: rtl/seg7_sequencer.sv
// Frame/animation sequencer feeding the 7-segment decoder.
module seg7_sequencer
    import seg7_pkg::*;
#(
    parameter int unsigned PRESCALE_BASE = 1000000,
    parameter int unsigned PRESCALE_W    = 27,
    parameter int unsigned LOOPS         = 2
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               ena,
    input  logic [SPEED_W-1:0] speed,
    input  logic               pause,
    input  logic               mode_auto,
    input  logic               btn_next,
    output logic [CNT_W-1:0]   counter,
    output anim_t              animation,
    output logic               frame_strobe
);

    logic [CNT_W-1:0]  counter_q, counter_d;
    anim_t             anim_q, anim_d;
    logic              strobe_q, strobe_d;
    logic [LOOP_W-1:0] loop_q, loop_d, loop_inc;
    logic              sync1_q, sync2_q, prev_q;
    logic              btn_edge_c;
    logic              tick_c;
    logic              presc_clr_c;

    assign btn_edge_c  = sync2_q & ~prev_q;
    assign presc_clr_c = ena & btn_edge_c;

    seg7_prescaler #(
        .PRESCALE_BASE (PRESCALE_BASE),
        .PRESCALE_W    (PRESCALE_W)
    ) u_prescaler (
        .clk      (clk),
        .rst_n    (rst_n),
        .ena_i    (ena),
        .clr_i    (presc_clr_c),
        .speed_i  (speed),
        .tick_c_o (tick_c)
    );

    // Button synchronizer and edge history; frozen with ena so an edge is never lost.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync1_q <= 1'b0;
            sync2_q <= 1'b0;
            prev_q  <= 1'b0;
        end else if (ena) begin
            sync1_q <= btn_next;
            sync2_q <= sync1_q;
            prev_q  <= sync2_q;
        end
    end

    // Sequencing: button edge beats tick; pause discards ticks only.
    always_comb begin
        counter_d = counter_q;
        anim_d    = anim_q;
        strobe_d  = strobe_q;
        loop_d    = loop_q;
        loop_inc  = (loop_q >= LOOP_W'(LOOPS)) ? loop_q : loop_q + LOOP_W'(1);
        if (ena) begin
            strobe_d = 1'b0;
            if (btn_edge_c) begin
                anim_d    = anim_next(anim_q);
                counter_d = '0;
                loop_d    = '0;
                strobe_d  = 1'b1;
            end else if (tick_c && !pause) begin
                strobe_d = 1'b1;
                if (counter_q < frame_len(anim_q) - CNT_W'(1)) begin
                    counter_d = counter_q + CNT_W'(1);
                end else begin
                    counter_d = '0;
                    loop_d    = loop_inc;
                    if (mode_auto && (loop_inc >= LOOP_W'(LOOPS))) begin
                        loop_d = '0;
                        anim_d = anim_next(anim_q);
                    end
                end
            end
        end
    end

    // State and output registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            counter_q <= '0;
            anim_q    <= '0;
            strobe_q  <= 1'b0;
            loop_q    <= '0;
        end else begin
            counter_q <= counter_d;
            anim_q    <= anim_d;
            strobe_q  <= strobe_d;
            loop_q    <= loop_d;
        end
    end

    assign counter      = counter_q;
    assign animation    = anim_q;
    assign frame_strobe = strobe_q;

endmodule

// File: tb/tb_seg7_sequencer.sv
// Directed bench for seg7_sequencer with PRESCALE_BASE=4, LOOPS=2.
module tb_seg7_sequencer;

    logic       clk;
    logic       rst_n;
    logic       ena;
    logic [2:0] speed;
    logic       pause;
    logic       mode_auto;
    logic       btn_next;
    logic [3:0] counter;
    logic [3:0] animation;
    logic       frame_strobe;

    int checks   = 0;
    int failures = 0;

    seg7_sequencer #(
        .PRESCALE_BASE (4),
        .PRESCALE_W    (12),
        .LOOPS         (2)
    ) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .ena          (ena),
        .speed        (speed),
        .pause        (pause),
        .mode_auto    (mode_auto),
        .btn_next     (btn_next),
        .counter      (counter),
        .animation    (animation),
        .frame_strobe (frame_strobe)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Advance n cycles; inputs are driven and outputs sampled on the falling edge.
    task automatic cyc(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic chk(input string tag, input int obs, input int exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    // One button press: edge lands on the 3rd rising edge, then the synchronizer drains.
    task automatic press();
        btn_next = 1'b1;
        cyc(3);
        btn_next = 1'b0;
        cyc(3);
    endtask

    initial begin
        rst_n     = 1'b1;
        ena       = 1'b1;
        speed     = 3'd0;
        pause     = 1'b0;
        mode_auto = 1'b0;
        btn_next  = 1'b0;
        #1 rst_n = 1'b0;
        #1;
        chk("rst_counter", int'(counter), 0);
        chk("rst_anim", int'(animation), 0);
        chk("rst_strobe", int'(frame_strobe), 0);
        cyc(2);
        rst_n = 1'b1;

        // 1: count through animation 0 (length 10), strobe every 4 cycles
        for (int k = 1; k <= 10; k++) begin
            cyc(3);
            chk("t1_no_strobe", int'(frame_strobe), 0);
            cyc(1);
            chk("t1_strobe", int'(frame_strobe), 1);
            chk("t1_counter", int'(counter), k % 10);
            chk("t1_anim", int'(animation), 0);
        end

        // 3: button held 10 cycles with counter at 5
        cyc(20);
        chk("t3_pre_counter", int'(counter), 5);
        btn_next = 1'b1;
        cyc(2);
        chk("t3_anim_before_edge", int'(animation), 0);
        chk("t3_counter_before_edge", int'(counter), 5);
        cyc(1);
        chk("t3_anim_edge", int'(animation), 1);
        chk("t3_counter_edge", int'(counter), 0);
        chk("t3_strobe_edge", int'(frame_strobe), 1);
        cyc(7);
        chk("t3_anim_held", int'(animation), 1);
        chk("t3_counter_held", int'(counter), 1);
        chk("t3_strobe_held", int'(frame_strobe), 0);
        btn_next = 1'b0;

        // 4: button edge coincident with a tick
        cyc(1);
        chk("t4_counter_tick", int'(counter), 2);
        chk("t4_strobe_tick", int'(frame_strobe), 1);
        cyc(1);
        btn_next = 1'b1;
        cyc(2);
        chk("t4_anim_before", int'(animation), 1);
        chk("t4_counter_before", int'(counter), 2);
        cyc(1);
        chk("t4_anim_collide", int'(animation), 2);
        chk("t4_counter_collide", int'(counter), 0);
        chk("t4_strobe_collide", int'(frame_strobe), 1);
        cyc(1);
        chk("t4_strobe_single", int'(frame_strobe), 0);
        chk("t4_counter_after", int'(counter), 0);
        btn_next = 1'b0;

        // 5a: pause freezes sequencing, button still works
        pause = 1'b1;
        for (int k = 0; k < 20; k++) begin
            cyc(1);
            chk("t5_pause_strobe", int'(frame_strobe), 0);
        end
        chk("t5_pause_counter", int'(counter), 0);
        chk("t5_pause_anim", int'(animation), 2);
        btn_next = 1'b1;
        cyc(2);
        chk("t5_pause_anim_before", int'(animation), 2);
        cyc(1);
        chk("t5_pause_btn_anim", int'(animation), 3);
        chk("t5_pause_btn_strobe", int'(frame_strobe), 1);
        btn_next = 1'b0;
        cyc(1);
        chk("t5_pause_btn_strobe_off", int'(frame_strobe), 0);
        pause = 1'b0;
        cyc(1);
        chk("t5_resume_wait1", int'(frame_strobe), 0);
        cyc(1);
        chk("t5_resume_wait2", int'(frame_strobe), 0);
        cyc(1);
        chk("t5_resume_strobe", int'(frame_strobe), 1);
        chk("t5_resume_counter", int'(counter), 1);

        // 5b: ena=0 holds everything, prescaler included
        ena = 1'b0;
        cyc(10);
        chk("t5_ena_counter", int'(counter), 1);
        chk("t5_ena_anim", int'(animation), 3);
        ena = 1'b1;
        for (int k = 0; k < 3; k++) begin
            cyc(1);
            chk("t5_ena_resume_wait", int'(frame_strobe), 0);
        end
        cyc(1);
        chk("t5_ena_resume_strobe", int'(frame_strobe), 1);
        chk("t5_ena_resume_counter", int'(counter), 2);

        // 2: auto-advance from animation 7 (length 2)
        pause = 1'b1;
        repeat (4) press();
        chk("t2_sel_anim7", int'(animation), 7);
        chk("t2_sel_counter", int'(counter), 0);
        mode_auto = 1'b1;
        pause     = 1'b0;
        cyc(1);
        chk("t2_c1", int'(counter), 1);
        chk("t2_a7_1", int'(animation), 7);
        cyc(4);
        chk("t2_c0", int'(counter), 0);
        chk("t2_a7_2", int'(animation), 7);
        cyc(4);
        chk("t2_c1b", int'(counter), 1);
        chk("t2_a7_3", int'(animation), 7);
        cyc(4);
        chk("t2_adv_anim", int'(animation), 8);
        chk("t2_adv_counter", int'(counter), 0);
        chk("t2_adv_strobe", int'(frame_strobe), 1);

        // 2b: wrap from animation 11 to 0
        pause = 1'b1;
        repeat (3) press();
        chk("t2_sel_anim11", int'(animation), 11);
        pause = 1'b0;
        cyc(1);
        chk("t2w_c1", int'(counter), 1);
        cyc(4);
        chk("t2w_c0", int'(counter), 0);
        chk("t2w_a11", int'(animation), 11);
        cyc(4);
        chk("t2w_c1b", int'(counter), 1);
        cyc(4);
        chk("t2w_wrap_anim", int'(animation), 0);
        chk("t2w_wrap_counter", int'(counter), 0);

        // 6: speed 3 -> 0 with the prescaler at 20
        speed = 3'd3;
        cyc(20);
        chk("t6_slow_counter", int'(counter), 0);
        chk("t6_slow_strobe", int'(frame_strobe), 0);
        speed = 3'd0;
        cyc(1);
        chk("t6_forced_strobe", int'(frame_strobe), 1);
        chk("t6_forced_counter", int'(counter), 1);
        for (int k = 0; k < 3; k++) begin
            cyc(1);
            chk("t6_period_wait", int'(frame_strobe), 0);
        end
        cyc(1);
        chk("t6_period_strobe", int'(frame_strobe), 1);
        chk("t6_period_counter", int'(counter), 2);

        // 6b: asynchronous reset mid-frame
        cyc(2);
        chk("t6_pre_rst_counter", int'(counter), 2);
        #2 rst_n = 1'b0;
        #1;
        chk("t6_async_counter", int'(counter), 0);
        chk("t6_async_anim", int'(animation), 0);
        chk("t6_async_strobe", int'(frame_strobe), 0);
        @(negedge clk);
        rst_n = 1'b1;
        cyc(3);
        chk("t6_post_rst_wait", int'(frame_strobe), 0);
        cyc(1);
        chk("t6_post_rst_strobe", int'(frame_strobe), 1);
        chk("t6_post_rst_counter", int'(counter), 1);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/seg7_sequencer.md
Name: seg7_sequencer

Overview:
Timing and sequencing stage that drives the 7-segment decoder. It produces the frame index (counter) and the animation select (animation) that the decoder maps to segment patterns. It contains a speed-selectable prescaler, per-animation frame-length wrap, a synchronized "next animation" button, an auto-cycle mode and a pause control. Its outputs connect directly to the decoder inputs.

Parameters:
PRESCALE_BASE, 1000000, number of clk cycles per frame at speed=0; must be >= 2
PRESCALE_W, 27, prescaler counter width; must hold PRESCALE_BASE<<7
LOOPS, 2, complete passes of an animation before auto-advance; range 1..15

Ports:
clk  input  1  system clock
rst_n  input  1  asynchronous active-low reset
ena  input  1  global enable; when 0, all state holds (the prescaler included)
speed  input  3  frame period = PRESCALE_BASE << speed cycles
pause  input  1  freezes counter and animation; the prescaler still runs
mode_auto  input  1  1 = advance animation after LOOPS passes
btn_next  input  1  asynchronous pushbutton; a rising edge selects the next animation
counter  output  4  frame index to the decoder
animation  output  4  animation select to the decoder, 0..11
frame_strobe  output  1  one-cycle pulse on every counter update

Behaviour:
- Reset (rst_n=0, asynchronous): counter=0, animation=0, frame_strobe=0, prescaler=0, loop count=0, button sync flops=0.
- Frame lengths (FRAME_LEN[animation]):
  - 0:10, 1:12, 2..6:6
  - 7:2, 8:4, 9:4, 10:2, 11:2
- Prescaler:
  - Counts 0..(PRESCALE_BASE<<speed)-1 and wraps to 0.
  - tick=1 in the cycle where the count equals the limit.
  - If speed changes mid-period and the count is already >= the new limit, force tick and wrap in that cycle; no overflow.
- On a tick with ena=1, pause=0 and no button edge:
  - If counter < FRAME_LEN-1: counter++.
  - Otherwise: counter=0 and loop count++.
  - If mode_auto=1 and the loop count reaches LOOPS: loop count=0 and animation advances (11 wraps to 0).
  - frame_strobe=1 for exactly that cycle.
- Button path:
  - btn_next passes through a 2-flop synchronizer plus a previous-value flop.
  - edge = sync2 & ~prev.
  - animation updates on the 3rd rising clk edge after btn_next rises (setup met).
  - On an edge (ena=1): animation advances (11 wraps to 0); counter, prescaler and loop count clear; frame_strobe=1.
  - The edge is honoured even when pause=1 or mode_auto=0.
- Simultaneous button edge and tick: the button wins and the tick is discarded.
- A held button produces exactly one advance.
- pause=1: counter, animation and loop count hold; ticks are discarded; frame_strobe stays 0.
- ena=0: every register holds; the button edge is not lost, because the sync flops also hold.
- Counter invariant: counter is always < FRAME_LEN[animation]. On any animation change the counter is already 0.
- Output timing: all outputs are registered with no combinational path from inputs; the decoder sees stable values for the entire frame.

Decomposition:
- Package seg7_pkg holds:
  - NUM_ANIM=12
  - typedef anim_t (4 bits)
  - the FRAME_LEN constant function/array for 0..11
  - ANIM_LAST=11
- Natural sub-module: seg7_prescaler, containing the prescaler counter with speed shift and tick output.
- Button sync, edge detect and sequencing logic stay in seg7_sequencer.

Test Plan:
All scenarios use PRESCALE_BASE=4 and LOOPS=2.
1. Reset and count: release rst_n; speed=0, mode_auto=0 -> frame_strobe every 4 cycles; counter 0..9 then wraps to 0; animation stays 0.
2. Auto-advance: mode_auto=1, animation 7 (len 2) -> counter 0,1,0,1 then animation=8, counter=0; from 11, two passes of len 2 -> animation=0.
3. Button: pulse btn_next high for 10 cycles with counter=5 -> exactly one advance to animation=1 on the 3rd edge; counter=0; one frame_strobe; no second advance.
4. Collision: align the button edge with a tick cycle -> animation+1, counter=0, single frame_strobe; the tick increment is absent.
5. Pause/ena: pause=1 for 20 cycles -> no strobe and outputs frozen, button still advances; ena=0 -> prescaler frozen, counting resumes from the held value.
6. Speed change: speed 3→0 with the prescaler at 20 -> tick in the next cycle and period 4 afterwards; assert rst_n low mid-frame -> all outputs 0 immediately, without waiting for a clock.
